btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
- Upstream conditioning stage for the push-button that drives the `light` controller's `btn` input.
- Synchronises the raw pad signal and debounces it.
- Emits a clean level plus single-cycle press, release, short-press and long-press strobes.
- `light` consumes `btn_level`; the strobes feed lock-sequencing logic.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles (after sync) required to accept a level change; must be >= 1.
- LONG_CYCLES, 32, cycles after `press_pulse` at which `long_pulse` fires; must be >= 1.
- CNT_W, $clog2(LONG_CYCLES+1), width of the hold counter; the debounce counter width is derived from DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all flops rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_raw  input  1  asynchronous button pad, active-high, may bounce.
- btn_level  output  1  debounced level; drives `light.btn`.
- press_pulse  output  1  one-cycle strobe when `btn_level` rises.
- release_pulse  output  1  one-cycle strobe when `btn_level` falls.
- short_pulse  output  1  one-cycle strobe on a release that occurs before `long_pulse` fired.
- long_pulse  output  1  one-cycle strobe once per press, LONG_CYCLES cycles after `press_pulse`.

Behaviour:
- Reset (reset=0, asynchronous):
  - Sync flops s1 and s2 = 0; state = IDLE; both counters = 0.
  - All outputs = 0 immediately, with no pulses generated.
  - After reset deasserts, a `btn_raw` that is already high is treated as a fresh press and debounced normally.
- Synchroniser: two flops, btn_raw -> s1 -> s2. Only s2 is used downstream.
- FSM states:
  - IDLE: stable low.
  - PRESS_WAIT: s2=1, counting.
  - HELD: stable high.
  - RELEASE_WAIT: s2=0, counting.
- IDLE: when s2=1, go to PRESS_WAIT with db_cnt=1.
- PRESS_WAIT:
  - If s2=0, return to IDLE and clear db_cnt (glitch rejected).
  - Else if db_cnt==DEBOUNCE_CYCLES-1, go to HELD, clear db_cnt, set btn_level=1, pulse press_pulse, clear hold_cnt and long_done.
  - Else increment db_cnt.
- HELD:
  - If s2=0, go to RELEASE_WAIT with db_cnt=1.
  - hold_cnt increments every cycle in HELD and saturates at LONG_CYCLES.
  - long_pulse fires on the single edge where hold_cnt reaches LONG_CYCLES (cycles counted from press_pulse), then sets long_done.
- RELEASE_WAIT:
  - If s2=1, return to HELD and clear db_cnt. hold_cnt keeps its value; RELEASE_WAIT cycles count toward the long threshold, so long_pulse may fire here.
  - If db_cnt==DEBOUNCE_CYCLES-1, go to IDLE, set btn_level=0, pulse release_pulse, and pulse short_pulse in the same cycle if long_done=0.
  - Else increment db_cnt.
- Latency:
  - Let E0 be the first edge that samples btn_raw=1.
  - btn_level and press_pulse become high after edge E(DEBOUNCE_CYCLES+1), i.e. 5 cycles with default parameters.
  - Release is symmetric.
- All outputs are registered. Pulses are exactly one cycle wide.
- press_pulse and release_pulse are never high in the same cycle.
- DEBOUNCE_CYCLES=1: a change is accepted on the edge after s2 changes; the PRESS_WAIT/RELEASE_WAIT compare is satisfied immediately.
- Reset asserted during HELD: outputs drop to 0 asynchronously; no release_pulse or short_pulse is generated.

Decomposition:
- Package `lock_pkg`:
  - Localparam state encodings IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3.
  - Default DEBOUNCE_CYCLES and LONG_CYCLES constants, shared with `light`.
- Sub-module `sync_2ff`: 2-flop synchroniser with clk and active-low async reset, reused for other pad inputs.
- The FSM and counters stay in `btn_debounce`.

Test Plan (10 ns clock, defaults):
1. reset=0 for 21 ns with btn_raw=1 -> all outputs stay 0; after deassert -> press_pulse and btn_level rise 5 edges after the first sampling edge.
2. btn_raw high for 1 cycle (10 ns) from idle -> no press_pulse; btn_level stays 0; FSM returns to IDLE.
3. btn_raw high for 10 cycles, then low -> press_pulse at E5; release_pulse and short_pulse together 5 edges after the falling sample; btn_level is high for exactly 10 cycles.
4. Bounce: btn_raw 1 for 3 cycles, 0 for 1, then steady 1 -> a single press_pulse, 5 edges after the final rising sample.
5. btn_raw high for 50 cycles (500 ns) -> long_pulse exactly once, 32 cycles after press_pulse; on release, release_pulse with short_pulse=0.
6. While in HELD, pulse reset=0 for 1 cycle -> btn_level=0 immediately with no release_pulse; with btn_raw still 1, a new press_pulse occurs 5 edges after reset deasserts.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared constants for the lock front-end: debounce FSM encodings and the
// default timing parameters used by both btn_debounce and light.
package lock_pkg;

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int LONG_CYCLES_DEF     = 32;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs; only q may be used
// by downstream logic.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit a clean level
// plus press / release / short-press / long-press single-cycle strobes.
module btn_debounce
  import lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter int CNT_W           = $clog2(LONG_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic [1:0] state_dbg
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  logic             s2;
  logic [1:0]       state;
  logic [DB_W-1:0]  db_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic             long_done;
  logic             db_done;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (s2)
  );

  // db_cnt is 0 on entry to IDLE/HELD, so with DEBOUNCE_CYCLES=1 the first
  // differing s2 sample is accepted directly without visiting a wait state.
  assign db_done   = (db_cnt == DB_LAST);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      long_done     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;

      // Hold time keeps running while a release is still being debounced.
      if (state == HELD || state == RELEASE_WAIT) begin
        if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + HOLD_ONE;
        end
        if (hold_cnt == HOLD_MAX - HOLD_ONE && !long_done) begin
          long_pulse <= 1'b1;
          long_done  <= 1'b1;
        end
      end

      case (state)
        IDLE, PRESS_WAIT: begin
          if (!s2) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_done) begin
            state       <= HELD;
            db_cnt      <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            hold_cnt    <= '0;
            long_done   <= 1'b0;
          end else if (state == IDLE) begin
            state  <= PRESS_WAIT;
            db_cnt <= DB_ONE;
          end else begin
            db_cnt <= db_cnt + DB_ONE;
          end
        end

        HELD, RELEASE_WAIT: begin
          if (s2) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (db_done) begin
            state         <= IDLE;
            db_cnt        <= '0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
            short_pulse   <= !long_done;
          end else if (state == HELD) begin
            state  <= RELEASE_WAIT;
            db_cnt <= DB_ONE;
          end else begin
            db_cnt <= db_cnt + DB_ONE;
          end
        end

        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: an edge-history model checked every cycle, plus
// directed press/bounce/long/reset scenarios with hand-computed edge times.
module tb_btn_debounce;

  localparam int DC = 4;
  localparam int LC = 32;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_raw;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_pulse;
  logic       long_pulse;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DC),
    .LONG_CYCLES     (LC)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_pulse   (short_pulse),
    .long_pulse    (long_pulse),
    .state_dbg     (state_dbg)
  );

  // Edge index and what each edge saw on the inputs.
  int cyc      = 0;
  bit edge_rst = 1'b0;
  bit edge_raw = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    edge_rst <= rst_n;
    edge_raw <= btn_raw;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: s2 at edge k is the raw value sampled at edge k-2 (zeros after
  // reset). The level flips once the last DC s2 samples all disagree with it.
  // Vector layout: {level, press, release, short, long}.
  logic [4:0] exp_q[$];
  bit         raw_q[$];
  bit         m_level;
  int         m_press_edge;

  task automatic model_reset();
    raw_q.delete();
    for (int i = 0; i < DC + 2; i++) raw_q.push_back(1'b0);
    m_level      = 1'b0;
    m_press_edge = 0;
  endtask

  task automatic model_step();
    logic [4:0] e;
    bit         flip;
    int         since;
    e     = '0;
    flip  = 1'b1;
    for (int i = 0; i < DC; i++) begin
      if (raw_q[raw_q.size() - 2 - i] == m_level) flip = 1'b0;
    end
    since = cyc - m_press_edge;
    if (m_level && since == LC) e[0] = 1'b1;
    if (flip && !m_level) begin
      e[3]         = 1'b1;
      m_press_edge = cyc;
    end
    if (flip && m_level) begin
      e[2] = 1'b1;
      e[1] = (since <= LC);
    end
    if (flip) m_level = !m_level;
    e[4] = m_level;
    exp_q.push_back(e);
    raw_q.push_back(edge_raw);
    void'(raw_q.pop_front());
  endtask

  // Pulse log taken from the DUT for the directed edge-time checks.
  int press_cnt = 0, rel_cnt = 0, short_cnt = 0, long_cnt = 0;
  int press_cyc = -1, rel_cyc = -1, short_cyc = -1, long_cyc = -1;

  initial begin
    logic [4:0] e;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n || !edge_rst) begin
        model_reset();
        exp_q.push_back(5'b0);
      end else begin
        model_step();
      end
      e = exp_q.pop_front();
      check("btn_level",     btn_level,     e[4]);
      check("press_pulse",   press_pulse,   e[3]);
      check("release_pulse", release_pulse, e[2]);
      check("short_pulse",   short_pulse,   e[1]);
      check("long_pulse",    long_pulse,    e[0]);
      if (press_pulse)   begin press_cnt++; press_cyc = cyc; end
      if (release_pulse) begin rel_cnt++;   rel_cyc   = cyc; end
      if (short_pulse)   begin short_cnt++; short_cyc = cyc; end
      if (long_pulse)    begin long_cnt++;  long_cyc  = cyc; end
    end
  end

  // ---------------- driver tasks ----------------
  // Advance n rising edges and land 2 time units after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int e0, p0, r0, s0, l0;

    // 1: reset held with button already down, then a fresh press.
    rst_n   = 1'b0;
    btn_raw = 1'b1;
    #3;
    check("rst_level", btn_level, 0);
    check("rst_press", press_pulse, 0);
    check("rst_state", state_dbg, 0);
    #18;
    rst_n = 1'b1;
    e0    = cyc + 1;
    step(8);
    check("t1_press_cnt", press_cnt, 1);
    check("t1_press_edge", press_cyc, e0 + 5);
    check("t1_level", btn_level, 1);
    btn_raw = 1'b0;
    e0      = cyc + 1;
    step(8);
    check("t1_rel_edge", rel_cyc, e0 + 5);
    check("t1_short_edge", short_cyc, e0 + 5);

    // 2: single-cycle glitch is rejected.
    p0      = press_cnt;
    btn_raw = 1'b1;
    step(1);
    btn_raw = 1'b0;
    step(8);
    check("t2_press_cnt", press_cnt, p0);
    check("t2_level", btn_level, 0);
    check("t2_state_idle", state_dbg, 0);

    // 3: ten-cycle press gives a ten-cycle level and a short press.
    p0 = press_cnt; r0 = rel_cnt; s0 = short_cnt; l0 = long_cnt;
    btn_raw = 1'b1;
    e0      = cyc + 1;
    step(10);
    btn_raw = 1'b0;
    step(8);
    check("t3_press_edge", press_cyc, e0 + 5);
    check("t3_rel_edge", rel_cyc, e0 + 15);
    check("t3_level_width", rel_cyc - press_cyc, 10);
    check("t3_short_cnt", short_cnt, s0 + 1);
    check("t3_short_edge", short_cyc, e0 + 15);
    check("t3_counts", {press_cnt - p0, rel_cnt - r0, long_cnt - l0}, {32'd1, 32'd1, 32'd0});

    // 4: bounce 1,1,1,0 then steady high -> one press after the last rise.
    p0 = press_cnt;
    btn_raw = 1'b1;
    e0      = cyc + 1;
    step(3);
    btn_raw = 1'b0;
    step(1);
    btn_raw = 1'b1;
    step(12);
    check("t4_press_cnt", press_cnt, p0 + 1);
    check("t4_press_edge", press_cyc, e0 + 4 + 5);
    btn_raw = 1'b0;
    step(8);
    check("t4_rel_edge", rel_cyc, e0 + 16 + 5);

    // 5: fifty-cycle hold -> one long press, release without short.
    p0 = press_cnt; s0 = short_cnt; l0 = long_cnt;
    btn_raw = 1'b1;
    e0      = cyc + 1;
    step(50);
    btn_raw = 1'b0;
    step(8);
    check("t5_long_cnt", long_cnt, l0 + 1);
    check("t5_long_edge", long_cyc, e0 + 37);
    check("t5_long_delay", long_cyc - press_cyc, 32);
    check("t5_rel_edge", rel_cyc, e0 + 55);
    check("t5_short_cnt", short_cnt, s0);

    // 6: reset pulse while held -> silent drop, then a fresh press.
    p0 = press_cnt;
    btn_raw = 1'b1;
    step(10);
    check("t6_held", btn_level, 1);
    r0 = rel_cnt; s0 = short_cnt;
    rst_n = 1'b0;
    #1;
    check("t6_async_level", btn_level, 0);
    step(1);
    rst_n = 1'b1;
    e0    = cyc + 1;
    step(10);
    check("t6_press_cnt", press_cnt, p0 + 2);
    check("t6_press_edge", press_cyc, e0 + 5);
    check("t6_no_release", rel_cnt, r0);
    check("t6_no_short", short_cnt, s0);
    btn_raw = 1'b0;
    step(8);
    check("t6_final_level", btn_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
